// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag positions, FSM states
// and opcode classification helpers.
package alu_pkg;

    localparam logic [7:0] OP_ADD    = 8'h00;
    localparam logic [7:0] OP_ADDI   = 8'h08;
    localparam logic [7:0] OP_ADDU   = 8'h10;
    localparam logic [7:0] OP_ADDUI  = 8'h18;
    localparam logic [7:0] OP_ADDC   = 8'h20;
    localparam logic [7:0] OP_ADDCU  = 8'h28;
    localparam logic [7:0] OP_ADDCUI = 8'h30;
    localparam logic [7:0] OP_ADDCI  = 8'h38;
    localparam logic [7:0] OP_SUB    = 8'h40;
    localparam logic [7:0] OP_SUBI   = 8'h48;
    localparam logic [7:0] OP_CMP    = 8'h50;
    localparam logic [7:0] OP_CMPI   = 8'h58;
    localparam logic [7:0] OP_AND    = 8'h60;
    localparam logic [7:0] OP_OR     = 8'h68;
    localparam logic [7:0] OP_XOR    = 8'h70;
    localparam logic [7:0] OP_NOT    = 8'h78;
    localparam logic [7:0] OP_LSH    = 8'h80;
    localparam logic [7:0] OP_LSHI   = 8'h88;
    localparam logic [7:0] OP_RSH    = 8'h90;
    localparam logic [7:0] OP_RSHI   = 8'h98;
    localparam logic [7:0] OP_ALSH   = 8'hA0;
    localparam logic [7:0] OP_ARSH   = 8'hA8;
    localparam logic [7:0] OP_NOP    = 8'hB0;

    localparam int Z_BIT = 4;
    localparam int C_BIT = 3;
    localparam int F_BIT = 2;
    localparam int N_BIT = 1;
    localparam int L_BIT = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [7:0] op);
        case (op)
            OP_LSH, OP_LSHI, OP_RSH, OP_RSHI, OP_ALSH, OP_ARSH: is_shift = 1'b1;
            default:                                            is_shift = 1'b0;
        endcase
    endfunction

    // Defined opcodes are exactly the multiples of 8 from ADD up to NOP.
    function automatic logic is_legal(input logic [7:0] op);
        is_legal = (op[2:0] == 3'b000) && (op <= OP_NOP);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// One-bit-per-cycle shifter with down-counter. The load edge already applies the
// first bit, so an n-bit shift needs n-1 further steps.
module alu_shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amount,
    input  logic             dir_left,
    input  logic             arith,
    output logic [WIDTH-1:0] next_value,
    output logic             next_carry,
    output logic             last
);

    logic [WIDTH-1:0] val_r;
    logic [SHW-1:0]   cnt_r;
    logic             left_r;
    logic             arith_r;
    logic [WIDTH-1:0] src_s;
    logic             left_s;
    logic             arith_s;

    // One-bit shift of either the incoming operand (load) or the held value (step).
    always_comb begin
        src_s      = val_r;
        left_s     = left_r;
        arith_s    = arith_r;
        next_value = val_r;
        next_carry = 1'b0;
        if (load) begin
            src_s   = data;
            left_s  = dir_left;
            arith_s = arith;
        end else begin
            src_s   = val_r;
            left_s  = left_r;
            arith_s = arith_r;
        end
        if (left_s) begin
            next_value = {src_s[WIDTH-2:0], 1'b0};
            next_carry = src_s[WIDTH-1];
        end else begin
            next_value = {arith_s & src_s[WIDTH-1], src_s[WIDTH-1:1]};
            next_carry = src_s[0];
        end
        if (load) begin
            last = (amount == SHW'(1));
        end else begin
            last = (cnt_r == SHW'(1));
        end
    end

    // Shift register, remaining-count and mode state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_r   <= {WIDTH{1'b0}};
            cnt_r   <= {SHW{1'b0}};
            left_r  <= 1'b0;
            arith_r <= 1'b0;
        end else if (load) begin
            val_r   <= next_value;
            cnt_r   <= amount - SHW'(1);
            left_r  <= dir_left;
            arith_r <= arith;
        end else if (step) begin
            val_r   <= next_value;
            cnt_r   <= cnt_r - SHW'(1);
        end else begin
            val_r   <= val_r;
            cnt_r   <= cnt_r;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with internal status-flag register and an iterative shifter
// behind a start/ready/done handshake.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] c,
    output logic [4:0]       flags
);

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] c_r, c_nxt_s, alu_c_s;
    logic [4:0]       flags_r, flags_nxt_s, alu_flags_s;
    logic             done_r, done_nxt_s, illegal_r, illegal_nxt_s;
    logic [WIDTH:0]   sum_s, diff_s;
    logic             cin_s, add_ovf_s, sub_ovf_s;
    logic [SHW-1:0]   amt_s;
    logic             sh_load_s, sh_step_s, sh_left_s, sh_arith_s;
    logic [WIDTH-1:0] sh_value_s;
    logic             sh_carry_s, sh_last_s;

    assign amt_s = b[SHW-1:0];

    // Single-cycle datapath: result and flag updates for every non-iterative op.
    always_comb begin
        case (opcode)
            OP_ADDC, OP_ADDCU, OP_ADDCUI, OP_ADDCI: cin_s = flags_r[C_BIT];
            default:                                cin_s = 1'b0;
        endcase
        sum_s       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
        diff_s      = {1'b0, a} - {1'b0, b};
        add_ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
        sub_ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
        alu_c_s     = c_r;
        alu_flags_s = flags_r;
        case (opcode)
            OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI: begin
                alu_c_s            = sum_s[WIDTH-1:0];
                alu_flags_s[C_BIT] = sum_s[WIDTH];
                alu_flags_s[F_BIT] = add_ovf_s;
                alu_flags_s[Z_BIT] = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
            end
            OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
                alu_c_s            = sum_s[WIDTH-1:0];
                alu_flags_s[C_BIT] = sum_s[WIDTH];
                alu_flags_s[Z_BIT] = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
            end
            OP_SUB, OP_SUBI: begin
                alu_c_s            = diff_s[WIDTH-1:0];
                alu_flags_s[C_BIT] = diff_s[WIDTH];
                alu_flags_s[F_BIT] = sub_ovf_s;
                alu_flags_s[Z_BIT] = (diff_s[WIDTH-1:0] == {WIDTH{1'b0}});
            end
            OP_CMP, OP_CMPI: begin
                alu_flags_s[Z_BIT] = (a == b);
                alu_flags_s[L_BIT] = (a < b);
                alu_flags_s[N_BIT] = ($signed(a) < $signed(b));
            end
            OP_AND: begin
                alu_c_s            = a & b;
                alu_flags_s[Z_BIT] = ((a & b) == {WIDTH{1'b0}});
            end
            OP_OR: begin
                alu_c_s            = a | b;
                alu_flags_s[Z_BIT] = ((a | b) == {WIDTH{1'b0}});
            end
            OP_XOR: begin
                alu_c_s            = a ^ b;
                alu_flags_s[Z_BIT] = ((a ^ b) == {WIDTH{1'b0}});
            end
            OP_NOT: begin
                alu_c_s            = ~a;
                alu_flags_s[Z_BIT] = (~a == {WIDTH{1'b0}});
            end
            // Only reached for a zero shift amount: pass a through, carry holds.
            OP_LSH, OP_LSHI, OP_RSH, OP_RSHI, OP_ALSH, OP_ARSH: begin
                alu_c_s            = a;
                alu_flags_s[Z_BIT] = (a == {WIDTH{1'b0}});
            end
            default: begin
                alu_c_s     = c_r;
                alu_flags_s = flags_r;
            end
        endcase
    end

    // Shift direction and fill mode for the accepted opcode.
    always_comb begin
        case (opcode)
            OP_LSH, OP_LSHI, OP_ALSH: begin
                sh_left_s  = 1'b1;
                sh_arith_s = 1'b0;
            end
            OP_ARSH: begin
                sh_left_s  = 1'b0;
                sh_arith_s = 1'b1;
            end
            default: begin
                sh_left_s  = 1'b0;
                sh_arith_s = 1'b0;
            end
        endcase
    end

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (sh_load_s),
        .step       (sh_step_s),
        .data       (a),
        .amount     (amt_s),
        .dir_left   (sh_left_s),
        .arith      (sh_arith_s),
        .next_value (sh_value_s),
        .next_carry (sh_carry_s),
        .last       (sh_last_s)
    );

    // FSM next-state and result/flag/pulse selection.
    always_comb begin
        state_nxt_s   = state_r;
        c_nxt_s       = c_r;
        flags_nxt_s   = flags_r;
        done_nxt_s    = 1'b0;
        illegal_nxt_s = 1'b0;
        sh_load_s     = 1'b0;
        sh_step_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (!is_legal(opcode)) begin
                        c_nxt_s       = {WIDTH{1'b0}};
                        illegal_nxt_s = 1'b1;
                        done_nxt_s    = 1'b1;
                    end else if (is_shift(opcode) && (amt_s != {SHW{1'b0}})) begin
                        sh_load_s = 1'b1;
                        if (sh_last_s) begin
                            c_nxt_s            = sh_value_s;
                            flags_nxt_s[Z_BIT] = (sh_value_s == {WIDTH{1'b0}});
                            flags_nxt_s[C_BIT] = sh_carry_s;
                            done_nxt_s         = 1'b1;
                        end else begin
                            state_nxt_s = ST_SHIFT;
                        end
                    end else begin
                        c_nxt_s     = alu_c_s;
                        flags_nxt_s = alu_flags_s;
                        done_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sh_step_s = 1'b1;
                if (sh_last_s) begin
                    c_nxt_s            = sh_value_s;
                    flags_nxt_s[Z_BIT] = (sh_value_s == {WIDTH{1'b0}});
                    flags_nxt_s[C_BIT] = sh_carry_s;
                    done_nxt_s         = 1'b1;
                    state_nxt_s        = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, result, flag and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            c_r       <= {WIDTH{1'b0}};
            flags_r   <= 5'b00000;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            c_r       <= c_nxt_s;
            flags_r   <= flags_nxt_s;
            done_r    <= done_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    assign ready   = (state_r == ST_IDLE);
    assign done    = done_r;
    assign illegal = illegal_r;
    assign c       = c_r;
    assign flags   = flags_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a table of back-to-back single-cycle ops, then
// hand-written shift, mid-shift start and mid-shift reset sequences.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  opcode;
    logic [15:0] a, b, c;
    logic        ready, done, illegal;
    logic [4:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [4:0]  f;
        logic        ill;
    } vec_t;

    vec_t vecs [24];

    alu_seq #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .opcode  (opcode),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .illegal (illegal),
        .c       (c),
        .flags   (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [15:0] aa, input logic [15:0] bb);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        a      = aa;
        b      = bb;
    endtask

    task automatic idle_inputs;
        @(negedge clk);
        start  = 1'b0;
        opcode = OP_NOP;
        a      = 16'hDEAD;
        b      = 16'hBEEF;
    endtask

    initial begin
        int done_seen;
        // flags = {Z,C,F,N,L}; each row depends on the flags left by the row before
        vecs[0]  = '{OP_ADD,    16'h7FFF, 16'h0001, 16'h8000, 5'h04, 1'b0};
        vecs[1]  = '{OP_ADDU,   16'hFFFF, 16'h0001, 16'h0000, 5'h1C, 1'b0};
        vecs[2]  = '{OP_ADDC,   16'h0001, 16'h0001, 16'h0003, 5'h00, 1'b0};
        vecs[3]  = '{OP_CMP,    16'hFFFE, 16'h0001, 16'h0003, 5'h02, 1'b0};
        vecs[4]  = '{OP_SUB,    16'h0001, 16'h0002, 16'hFFFF, 5'h0A, 1'b0};
        vecs[5]  = '{OP_SUBI,   16'h8000, 16'h0001, 16'h7FFF, 5'h06, 1'b0};
        vecs[6]  = '{OP_ADDCI,  16'h0001, 16'h0001, 16'h0002, 5'h02, 1'b0};
        vecs[7]  = '{OP_AND,    16'hF0F0, 16'h0F0F, 16'h0000, 5'h12, 1'b0};
        vecs[8]  = '{OP_OR,     16'hF0F0, 16'h0F0F, 16'hFFFF, 5'h02, 1'b0};
        vecs[9]  = '{OP_XOR,    16'hAAAA, 16'hAAAA, 16'h0000, 5'h12, 1'b0};
        vecs[10] = '{OP_NOT,    16'h0000, 16'h1234, 16'hFFFF, 5'h02, 1'b0};
        vecs[11] = '{OP_ADDI,   16'hFFFF, 16'h0001, 16'h0000, 5'h1A, 1'b0};
        vecs[12] = '{OP_ADDCUI, 16'h0001, 16'h0002, 16'h0004, 5'h02, 1'b0};
        vecs[13] = '{OP_CMPI,   16'h1234, 16'h1234, 16'h0004, 5'h10, 1'b0};
        vecs[14] = '{OP_CMP,    16'h0001, 16'hFFFF, 16'h0004, 5'h01, 1'b0};
        vecs[15] = '{OP_NOP,    16'h5555, 16'h5555, 16'h0004, 5'h01, 1'b0};
        vecs[16] = '{8'h01,     16'h1111, 16'h2222, 16'h0000, 5'h01, 1'b1};
        vecs[17] = '{8'hB8,     16'h1111, 16'h2222, 16'h0000, 5'h01, 1'b1};
        vecs[18] = '{OP_ADDU,   16'hFFFF, 16'h0002, 16'h0001, 5'h09, 1'b0};
        vecs[19] = '{OP_LSH,    16'h00F0, 16'h0000, 16'h00F0, 5'h09, 1'b0};
        vecs[20] = '{OP_RSHI,   16'h0000, 16'h0010, 16'h0000, 5'h19, 1'b0};
        vecs[21] = '{OP_XOR,    16'h0F0F, 16'h00FF, 16'h0FF0, 5'h09, 1'b0};
        vecs[22] = '{OP_ADDCU,  16'h7FFF, 16'h0000, 16'h8000, 5'h01, 1'b0};
        vecs[23] = '{OP_ADD,    16'h8000, 16'h8000, 16'h0000, 5'h1D, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        opcode = OP_NOP;
        a      = 16'h0000;
        b      = 16'h0000;
        #12;
        chk("reset c", 32'(c), 32'h0);
        chk("reset flags", 32'(flags), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset illegal", 32'(illegal), 32'h0);
        chk("reset ready", 32'(ready), 32'h1);
        @(negedge clk);
        reset = 1'b0;

        // start stays high across the loop: one op accepted every cycle
        for (int i = 0; i < 24; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            chk($sformatf("v%0d done", i), 32'(done), 32'h1);
            chk($sformatf("v%0d ready", i), 32'(ready), 32'h1);
            chk($sformatf("v%0d c", i), 32'(c), 32'(vecs[i].c));
            chk($sformatf("v%0d flags", i), 32'(flags), 32'(vecs[i].f));
            chk($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].ill));
        end
        idle_inputs();
        tick();
        chk("idle done", 32'(done), 32'h0);

        // ARSH by 4 with a start pulse and operand change mid-shift
        issue(OP_ARSH, 16'h8010, 16'h0004);
        tick();
        chk("arsh cyc1 ready", 32'(ready), 32'h0);
        chk("arsh cyc1 done", 32'(done), 32'h0);
        issue(OP_XOR, 16'hFFFF, 16'h0000);
        tick();
        chk("arsh cyc2 ready", 32'(ready), 32'h0);
        chk("arsh cyc2 done", 32'(done), 32'h0);
        idle_inputs();
        tick();
        chk("arsh cyc3 ready", 32'(ready), 32'h0);
        chk("arsh cyc3 done", 32'(done), 32'h0);
        tick();
        chk("arsh cyc4 ready", 32'(ready), 32'h1);
        chk("arsh cyc4 done", 32'(done), 32'h1);
        chk("arsh c", 32'(c), 32'hF801);
        chk("arsh flags", 32'(flags), 32'h05);
        tick();
        chk("arsh after done", 32'(done), 32'h0);
        chk("arsh c stable", 32'(c), 32'hF801);

        // single-bit shift completes in one cycle
        issue(OP_LSH, 16'h8001, 16'h0001);
        tick();
        chk("lsh1 ready", 32'(ready), 32'h1);
        chk("lsh1 done", 32'(done), 32'h1);
        chk("lsh1 c", 32'(c), 32'h0002);
        chk("lsh1 flags", 32'(flags), 32'h0D);
        idle_inputs();

        // two-bit logical right shift to zero
        issue(OP_RSH, 16'h0003, 16'h0002);
        tick();
        chk("rsh2 cyc1 ready", 32'(ready), 32'h0);
        chk("rsh2 cyc1 done", 32'(done), 32'h0);
        idle_inputs();
        tick();
        chk("rsh2 done", 32'(done), 32'h1);
        chk("rsh2 c", 32'(c), 32'h0000);
        chk("rsh2 flags", 32'(flags), 32'h1D);

        // reset in the middle of a 15-bit shift
        issue(OP_LSH, 16'h1234, 16'h000F);
        tick();
        idle_inputs();
        repeat (4) tick();
        chk("lsh15 busy", 32'(ready), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort c", 32'(c), 32'h0);
        chk("abort flags", 32'(flags), 32'h0);
        chk("abort ready", 32'(ready), 32'h1);
        chk("abort done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        chk("abort no done", 32'(done_seen), 32'h0);
        chk("abort c held", 32'(c), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the team's combinational 16-bit ALU. It executes the same 8-bit opcode set on WIDTH-bit operands and holds the processor status flags in an internal register, so ADDC-class ops consume a real carry. Shifts run iteratively, one bit per cycle, behind a start/done handshake. It sits between the register-file read ports and the writeback mux; the controller owns `start`.

## Interface
- `WIDTH`, 16: operand and result width, at least 4.
- `SHW`, $clog2(WIDTH): width of the shift-amount field taken from `b`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request; accepted only while `ready`=1.
- `opcode` in 8: operation, sampled on the accept edge.
- `a`, `b` in WIDTH: operands, sampled on the accept edge. Immediate forms arrive already extended.
- `ready` out 1: FSM is in IDLE.
- `done` out 1: one-cycle pulse when `c`/`flags` are updated.
- `illegal` out 1: one-cycle pulse, coincident with `done`, for an undefined opcode.
- `c` out WIDTH: registered result.
- `flags` out 5: [4]=Z, [3]=C, [2]=F, [1]=N, [0]=L.

## Operation
- Opcodes occupy bits [7:3]; bits [2:0] must be zero:
  - 0x00 ADD, 0x08 ADDI, 0x10 ADDU, 0x18 ADDUI
  - 0x20 ADDC, 0x28 ADDCU, 0x30 ADDCUI, 0x38 ADDCI
  - 0x40 SUB, 0x48 SUBI, 0x50 CMP, 0x58 CMPI
  - 0x60 AND, 0x68 OR, 0x70 XOR, 0x78 NOT
  - 0x80 LSH, 0x88 LSHI, 0x90 RSH, 0x98 RSHI, 0xA0 ALSH, 0xA8 ARSH, 0xB0 NOP
- Any other opcode is illegal: `c` is written to 0, flags hold, `illegal` pulses.
- Each I variant behaves exactly like its register form.
- Adds compute `c = a+b`, plus `flags.C` for the ADDC group. Carry-in is the flag value sampled at accept.
  - Signed forms (ADD, ADDI, ADDC, ADDCI) write C=carry-out, F=signed overflow, Z=(c==0).
  - Unsigned forms write C and Z only.
- SUB/SUBI: `c = a-b`. Writes C=borrow (a<b unsigned), F=signed overflow (operand signs differ and result sign differs from `a`), Z.
- CMP/CMPI: `c` holds. Writes Z=(a==b), L=(a<b unsigned), N=(a<b signed).
- AND, OR, XOR, NOT: NOT gives `~a`. These write Z only.
- Shifts use amount n = `b[SHW-1:0]`.
  - LSH, LSHI, ALSH: left, zero fill.
  - RSH, RSHI: logical right.
  - ARSH: right with sign fill.
  - Shifts write Z, and C = last bit shifted out. When n=0, `c=a` and C holds.
- NOP: `done` pulses; `c` and flags hold.
- Flags not listed for an op hold their value.
- FSM states:
  - IDLE: `ready`=1. On `start`, if the op is a shift with n>0, load the shifter and count, then go to SHIFT. Otherwise write `c`/flags on the same edge and stay in IDLE.
  - SHIFT: `ready`=0. Shift one bit per cycle and decrement the count. The edge that applies the final bit writes `c`/flags and returns to IDLE.

## Timing
- Reset values: `c`=0, `flags`=0, `done`=0, `illegal`=0, `ready`=1, state IDLE.
- Reset asserted mid-shift aborts the operation; no `done` is produced.
- Non-shift ops and zero-amount shifts:
  - `done` is high in the cycle after the accept edge.
  - `ready` stays 1, so back-to-back issue every cycle is legal.
  - An op accepted in a `done` cycle sees flags already updated.
- Shift with n≥1:
  - `done` is high n cycles after the accept edge.
  - `ready` is 0 for the n−1 cycles after accept, then 1 again in the `done` cycle.
- `start` while `ready`=0 is ignored, not queued.
- `a`, `b` and `opcode` may change after accept without effect.
- `c` and flags are stable from `done` until the next completion.

## Structure
- Package `alu_pkg`:
  - opcode localparams
  - flag bit indices (Z_BIT … L_BIT)
  - FSM state enum
  - `is_shift()` and `is_legal()` functions
- Sub-module `alu_shifter`: shift register plus down-counter, with load/step/last interface and direction/fill mode. The top level holds the FSM, the combinational single-cycle datapath and the flags register.

## Test plan
- Reset, then ADD a=0x7FFF, b=0x0001 → next cycle `c`=0x8000, F=1, C=0, Z=0, `done`=1.
- ADDU a=0xFFFF, b=0x0001 (C=1, Z=1), then ADDC a=0x0001, b=0x0001 → `c`=0x0003. ADDC results must reflect the registered carry.
- CMP a=0xFFFE, b=0x0001 → N=1, L=0, Z=0, `c` unchanged from the prior result.
- ARSH a=0x8010, b=4 → `ready` low 3 cycles, `done` on cycle 4, `c`=0xF801, C=0. `start` pulsed mid-shift is ignored.
- LSH a=0x00F0, b=0 → 1-cycle `done`, `c`=0x00F0. Then assert `reset` during LSH b=15 → `c`=0, flags=0, no `done`.
- Opcode 0x01 → `illegal` and `done` pulse, `c`=0, flags unchanged. Back-to-back XOR ops every cycle yield `done` every cycle.
